// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Oversampling UART receiver with 2-of-3 majority bit decisions,
//            per-frame latched format (data bits / parity / stop bits) and a
//            receive FIFO whose entries carry break, frame and parity flags.
// Options  : define UART_RX_BREAK_DETECT_EN to flag all-zero frames as line
//            breaks and hold in STOP until the line returns high.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int COUNTER_WIDTH = 16,
  parameter int DATA_WIDTH    = 9,
  parameter int SAMPLE_COUNT  = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rxpin,
  input  logic [COUNTER_WIDTH-1:0]      UART_CONFIG_DELAY_FRAMES,
  input  logic [4:0]                    UART_CONFIG_DATABITS,
  input  logic [1:0]                    UART_CONFIG_PARITY,
  input  logic [1:0]                    UART_CONFIG_STOPBITS,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_break,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun
);

  localparam int c_SW = $clog2(SAMPLE_COUNT);
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_BW = $clog2(DATA_WIDTH + 1);
`ifdef UART_RX_BREAK_DETECT_EN
  localparam int c_EW = DATA_WIDTH + 3;
`else
  localparam int c_EW = DATA_WIDTH + 2;
`endif

  localparam logic [1:0] c_PARITY_ODD  = 2'd1;
  localparam logic [1:0] c_PARITY_EVEN = 2'd2;
  localparam logic [1:0] c_STOP_TWO    = 2'd2;

  localparam logic [c_SW-1:0]          c_SMP_A    = c_SW'(SAMPLE_COUNT / 2 - 1);
  localparam logic [c_SW-1:0]          c_SMP_B    = c_SW'(SAMPLE_COUNT / 2);
  localparam logic [c_SW-1:0]          c_SMP_C    = c_SW'(SAMPLE_COUNT / 2 + 1);
  localparam logic [c_SW-1:0]          c_SMP_LAST = c_SW'(SAMPLE_COUNT - 1);
  localparam logic [c_SW-1:0]          c_SMP_ONE  = c_SW'(1);
  localparam logic [COUNTER_WIDTH-1:0] c_DIV_ONE  = COUNTER_WIDTH'(1);
  localparam logic [c_BW-1:0]          c_BIT_ONE  = c_BW'(1);
  localparam logic [c_BW-1:0]          c_BIT_MAX  = c_BW'(DATA_WIDTH);
  localparam logic [c_AW-1:0]          c_PTR_ONE  = c_AW'(1);
  localparam logic [c_AW:0]            c_CNT_ONE  = (c_AW + 1)'(1);
  localparam logic [c_AW:0]            c_CNT_FULL = (c_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Synchronizer and receive path
  logic [1:0]               r_sync;
  logic [1:0]               r_flush;
  logic                     w_rx;
  logic                     w_sync_ok;
  logic [COUNTER_WIDTH-1:0] r_div;
  logic [COUNTER_WIDTH-1:0] w_ratio;
  logic                     w_div_last;
  logic [c_SW-1:0]          r_samp;
  logic                     w_tick;
  logic                     w_decide;
  logic                     w_bit_end;
  logic                     r_smp_a;
  logic                     r_smp_b;
  logic                     w_bit;

  // Frame state
  state_t                   r_state;
  logic                     r_armed;
  logic [c_BW-1:0]          r_nbits;
  logic [c_BW-1:0]          w_nbits;
  logic [1:0]               r_parity_mode;
  logic                     r_stop_left;
  logic [c_BW-1:0]          r_bitidx;
  logic                     w_last_data;
  logic [DATA_WIDTH-1:0]    r_shift;
  logic                     r_par;
  logic                     w_par_total;
  logic                     w_perr;
  logic                     r_perr;
  logic                     r_ferr;
  logic                     w_ferr;
  logic                     r_brk_wait;
  logic                     r_push;
  logic [c_EW-1:0]          r_push_word;

  // FIFO
  logic [c_EW-1:0]          r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]          r_wr_ptr;
  logic [c_AW-1:0]          r_rd_ptr;
  logic [c_AW:0]            r_count;
  logic                     r_overrun;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_wr;
  logic [c_EW-1:0]          w_head;

  // Two-flop synchronizer plus a flush marker that says when r_sync reflects the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_flush <= 2'b00;
    end else begin
      r_sync  <= {r_sync[0], uart_rxpin};
      r_flush <= {r_flush[0], 1'b1};
    end
  end

  assign w_rx      = r_sync[1];
  assign w_sync_ok = r_flush[1];

  // Clocks per sample tick; a ratio of 0 or 1 ticks every clock.
  assign w_ratio    = UART_CONFIG_DELAY_FRAMES >> c_SW;
  assign w_div_last = (w_ratio <= c_DIV_ONE) || (r_div >= (w_ratio - c_DIV_ONE));
  assign w_tick     = (r_state != S_IDLE) && w_div_last;
  assign w_decide   = w_tick && (r_samp == c_SMP_C);
  assign w_bit_end  = w_tick && (r_samp == c_SMP_LAST);

  // Sample-tick divider and per-bit sample index, both parked at zero in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_samp <= '0;
    end else if (r_state == S_IDLE) begin
      r_div  <= '0;
      r_samp <= '0;
    end else if (w_div_last) begin
      r_div  <= '0;
      r_samp <= r_samp + c_SMP_ONE;
    end else begin
      r_div  <= r_div + c_DIV_ONE;
    end
  end

  // Capture the first two of the three mid-bit samples; the third is taken live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp_a <= 1'b1;
      r_smp_b <= 1'b1;
    end else begin
      if (w_tick && (r_samp == c_SMP_A)) r_smp_a <= w_rx;
      if (w_tick && (r_samp == c_SMP_B)) r_smp_b <= w_rx;
    end
  end

  assign w_bit       = (r_smp_a & r_smp_b) | (r_smp_a & w_rx) | (r_smp_b & w_rx);
  assign w_last_data = (r_bitidx == (r_nbits - c_BIT_ONE));
  assign w_ferr      = r_ferr | ~w_bit;

  // Clamp the requested data-bit count into 1..DATA_WIDTH.
  always_comb begin
    w_nbits = c_BW'(UART_CONFIG_DATABITS);
    if (UART_CONFIG_DATABITS == 5'd0) begin
      w_nbits = c_BIT_ONE;
    end else if (32'(UART_CONFIG_DATABITS) > DATA_WIDTH) begin
      w_nbits = c_BIT_MAX;
    end
  end

  // Parity error from the running data parity and the received parity bit.
  always_comb begin
    w_par_total = r_par ^ w_bit;
    case (r_parity_mode)
      c_PARITY_ODD:  w_perr = ~w_par_total;
      c_PARITY_EVEN: w_perr = w_par_total;
      default:       w_perr = w_par_total;
    endcase
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic r_allzero;
  logic w_brk;

  // Track whether every decided bit of the current frame has been 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_allzero <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_allzero <= 1'b1;
    end else if (w_decide && w_bit) begin
      r_allzero <= 1'b0;
    end
  end

  assign w_brk = r_allzero & ~w_bit;
`endif

  // Frame FSM: bit decisions at the third mid-bit sample, state steps at bit end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_armed       <= 1'b0;
      r_nbits       <= c_BIT_ONE;
      r_parity_mode <= 2'd0;
      r_stop_left   <= 1'b0;
      r_bitidx      <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_perr        <= 1'b0;
      r_ferr        <= 1'b0;
      r_brk_wait    <= 1'b0;
      r_push        <= 1'b0;
      r_push_word   <= '0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start needs the line to have been seen high since the last frame or reset.
          if (w_rx && w_sync_ok) r_armed <= 1'b1;
          if (!w_rx && r_armed) begin
            r_state       <= S_START;
            r_armed       <= 1'b0;
            r_nbits       <= w_nbits;
            r_parity_mode <= UART_CONFIG_PARITY;
            r_stop_left   <= (UART_CONFIG_STOPBITS == c_STOP_TWO);
            r_bitidx      <= '0;
            r_shift       <= '0;
            r_par         <= 1'b0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;
            r_brk_wait    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) r_state <= S_DATA;
          if (w_decide && w_bit) r_state <= S_IDLE;
        end
        S_DATA: begin
          if (w_decide) begin
            r_shift <= r_shift | (DATA_WIDTH'(w_bit) << r_bitidx);
            r_par   <= r_par ^ w_bit;
          end
          if (w_bit_end) begin
            if (w_last_data) begin
              r_state <= (r_parity_mode != 2'd0) ? S_PARITY : S_STOP;
            end else begin
              r_bitidx <= r_bitidx + c_BIT_ONE;
            end
          end
        end
        S_PARITY: begin
          if (w_decide) r_perr <= w_perr;
          if (w_bit_end) r_state <= S_STOP;
        end
        S_STOP: begin
          if (r_brk_wait) begin
            if (w_rx) begin
              r_brk_wait <= 1'b0;
              r_state    <= S_IDLE;
            end
          end else begin
            if (w_decide) begin
              if (!w_bit) r_ferr <= 1'b1;
              if (!r_stop_left) begin
                r_push <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                r_push_word <= {w_brk, w_ferr, r_perr, r_shift};
                if (w_brk) begin
                  r_brk_wait <= 1'b1;
                end else begin
                  r_state <= S_IDLE;
                end
`else
                r_push_word <= {w_ferr, r_perr, r_shift};
                r_state     <= S_IDLE;
`endif
              end
            end
            if (w_bit_end && r_stop_left) r_stop_left <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_valid = (r_count != '0);
  assign w_full  = (r_count == c_CNT_FULL);
  assign w_pop   = m_valid & m_ready;
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  // Receive FIFO: push from the FSM, pop on valid/ready, drop and flag when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_push & w_full & ~w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_push_word;
        r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (w_wr && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  assign fifo_count   = r_count;
  assign overrun      = r_overrun;
  assign m_data       = m_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign m_parity_err = m_valid & w_head[DATA_WIDTH];
  assign m_frame_err  = m_valid & w_head[DATA_WIDTH+1];
`ifdef UART_RX_BREAK_DETECT_EN
  assign m_break      = m_valid & w_head[DATA_WIDTH+2];
`else
  assign m_break      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed bench for uart_rx_fifo: nominal 8N1, 7E2 parity error,
//            FIFO overrun and drain order, start glitch, long break, and
//            reset in mid-frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int c_BIT = 160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rxpin;
  logic [15:0] cfg_delay;
  logic [4:0]  cfg_databits;
  logic [1:0]  cfg_parity;
  logic [1:0]  cfg_stopbits;
  logic [8:0]  m_data;
  logic        m_parity_err;
  logic        m_frame_err;
  logic        m_break;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  fifo_count;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  logic        clr_mon = 1'b0;
  logic [11:0] cap_q[$];
  int          valid_cycles;
  int          ovr_pulses;

  uart_rx_fifo dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .uart_rxpin               (uart_rxpin),
    .UART_CONFIG_DELAY_FRAMES (cfg_delay),
    .UART_CONFIG_DATABITS     (cfg_databits),
    .UART_CONFIG_PARITY       (cfg_parity),
    .UART_CONFIG_STOPBITS     (cfg_stopbits),
    .m_data                   (m_data),
    .m_parity_err             (m_parity_err),
    .m_frame_err              (m_frame_err),
    .m_break                  (m_break),
    .m_valid                  (m_valid),
    .m_ready                  (m_ready),
    .fifo_count               (fifo_count),
    .overrun                  (overrun)
  );

  always #5 clk = ~clk;

  // Record accepted entries {break, frame_err, parity_err, data}, valid cycles and overrun pulses.
  always @(negedge clk) begin
    if (clr_mon) begin
      cap_q.delete();
      valid_cycles = 0;
      ovr_pulses   = 0;
    end else if (rst_n) begin
      if (m_valid) valid_cycles++;
      if (overrun) ovr_pulses++;
      if (m_valid && m_ready) cap_q.push_back({m_break, m_frame_err, m_parity_err, m_data});
    end
  end

  function automatic logic [11:0] cap_at(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return 12'hFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    clr_mon = 1'b1;
    wait_clks(1);
    clr_mon = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    uart_rxpin = b;
    wait_clks(c_BIT);
  endtask

  // par: 0 none, 1 odd, 2 even; flip sends the wrong parity bit.
  task automatic send_frame(input logic [8:0] d, input int nbits, input int par,
                            input logic flip, input int nstop);
    logic p;
    p = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      p = p ^ d[i];
      send_bit(d[i]);
    end
    if (par != 0) send_bit(((par == 1) ? ~p : p) ^ flip);
    for (int i = 0; i < nstop; i++) send_bit(1'b1);
  endtask

  initial begin
    rst_n        = 1'b0;
    uart_rxpin   = 1'b1;
    m_ready      = 1'b0;
    cfg_delay    = 16'd160;
    cfg_databits = 5'd8;
    cfg_parity   = 2'd0;
    cfg_stopbits = 2'd1;
    wait_clks(3);

    // Reset state
    check("rst_m_valid", m_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_m_data", m_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_flags", {m_break, m_frame_err, m_parity_err}, 0);
    rst_n = 1'b1;
    wait_clks(5);

    // 8N1 0xA5 with m_ready high: one valid cycle, clean entry
    m_ready = 1'b1;
    mon_clear();
    send_frame(9'h0A5, 8, 0, 1'b0, 1);
    send_bit(1'b1);
    check("a5_entries", cap_q.size(), 1);
    check("a5_entry", cap_at(0), {3'b000, 9'h0A5});
    check("a5_valid_cycles", valid_cycles, 1);
    check("a5_fifo_count", fifo_count, 0);

    // 7E2 0x55 with the wrong parity bit
    cfg_databits = 5'd7;
    cfg_parity   = 2'd2;
    cfg_stopbits = 2'd2;
    mon_clear();
    send_frame(9'h055, 7, 2, 1'b1, 2);
    send_bit(1'b1);
    check("7e2_entries", cap_q.size(), 1);
    check("7e2_data", cap_at(0) & 12'h1FF, 9'h055);
    check("7e2_parity_err", cap_at(0) >> 9 & 12'h1, 1);
    check("7e2_frame_err", cap_at(0) >> 10 & 12'h1, 0);

    // Overrun: fill 8 entries with m_ready low, ninth frame is dropped
    cfg_databits = 5'd8;
    cfg_parity   = 2'd0;
    cfg_stopbits = 2'd1;
    m_ready = 1'b0;
    mon_clear();
    for (int k = 1; k <= 8; k++) send_frame(9'(k), 8, 0, 1'b0, 1);
    send_bit(1'b1);
    check("ovr_count_full", fifo_count, 8);
    check("ovr_no_pulse_yet", ovr_pulses, 0);
    check("ovr_head_held", m_data, 9'h001);
    send_frame(9'h009, 8, 0, 1'b0, 1);
    send_bit(1'b1);
    check("ovr_pulses", ovr_pulses, 1);
    check("ovr_count_after", fifo_count, 8);
    check("ovr_head_after", m_data, 9'h001);
    m_ready = 1'b1;
    wait_clks(12);
    check("drain_entries", cap_q.size(), 8);
    for (int k = 0; k < 8; k++) check("drain_order", cap_at(k), 12'(k + 1));
    check("drain_count", fifo_count, 0);

    // Quarter-bit glitch in IDLE, then a good frame
    mon_clear();
    uart_rxpin = 1'b0;
    wait_clks(c_BIT / 4);
    uart_rxpin = 1'b1;
    wait_clks(2 * c_BIT);
    check("glitch_no_push", cap_q.size(), 0);
    send_frame(9'h03C, 8, 0, 1'b0, 1);
    send_bit(1'b1);
    check("glitch_next_entries", cap_q.size(), 1);
    check("glitch_next_entry", cap_at(0), {3'b000, 9'h03C});

    // Line held low for 12 bit times
    mon_clear();
    uart_rxpin = 1'b0;
    wait_clks(12 * c_BIT);
    uart_rxpin = 1'b1;
    wait_clks(2 * c_BIT);
    check("break_entries", cap_q.size(), 1);
`ifdef UART_RX_BREAK_DETECT_EN
    check("break_entry", cap_at(0), 12'hC00);
`else
    check("break_entry", cap_at(0), 12'h400);
`endif

    // Reset in the middle of data bit 4, with one entry already queued
    m_ready = 1'b0;
    mon_clear();
    send_frame(9'h011, 8, 0, 1'b0, 1);
    send_bit(1'b1);
    check("prerst_valid", m_valid, 1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    uart_rxpin = 1'b0;
    wait_clks(c_BIT / 2);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_data", m_data, 0);
    check("midrst_flags", {overrun, m_break, m_frame_err, m_parity_err}, 0);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(c_BIT / 2);
    uart_rxpin = 1'b1;
    wait_clks(2 * c_BIT);
    check("postrst_no_push", fifo_count, 0);
    m_ready = 1'b1;
    mon_clear();
    send_frame(9'h0C3, 8, 0, 1'b0, 1);
    send_bit(1'b1);
    check("postrst_entries", cap_q.size(), 1);
    check("postrst_entry", cap_at(0), {3'b000, 9'h0C3});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
